// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, PC step and the prefetch FIFO entry type
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int PC_STEP = 4;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with flush and a registered head
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 4,
  parameter type T = fetch_entry_t,
  parameter T RST_VAL = T'(0)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  T                           din_i,
  output T                           head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  T mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic do_pop;
  assign do_pop = pop_i && count_q != '0;
  assign head_o = mem_q[rd_q];
  assign count_o = count_q;
  // pointer/count update; flush empties the queue without touching storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      mem_q <= '{default: RST_VAL};
    end else if (flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      assert (!(push_i && !do_pop && count_q == CW'(DEPTH)));
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction fetch with in-flight tracking and redirect flush
module fetch_unit import fetch_pkg::*; #(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter int              ILEN     = fetch_pkg::ILEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [ILEN-1:0] dec_instr
);
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;
  localparam entry_t RST_ENTRY = '{pc: RESET_PC, instr: '0};
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redir_pc;
  logic [CW-1:0] out_q, out_d, disc_q, disc_d, count;
  logic req_fire, push, pop;
  entry_t head;
  assign redir_pc = redirect_pc & ~XLEN'(3);
  assign imem_req_valid = i_rstn && !redirect && (int'(count) + int'(out_q)) < DEPTH;
  assign imem_req_addr = fetch_pc_q;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign push = imem_rsp_valid && disc_q == '0 && !redirect;
  assign dec_valid = count != '0;
  assign pop = dec_valid && dec_ready;
  assign dec_pc = head.pc;
  assign dec_instr = head.instr;
  // next-state: redirect wins; everything still in flight becomes stale
  always_comb begin
    fetch_pc_d = redirect ? redir_pc : req_fire ? fetch_pc_q + XLEN'(PC_STEP) : fetch_pc_q;
    rsp_pc_d = redirect ? redir_pc : push ? rsp_pc_q + XLEN'(PC_STEP) : rsp_pc_q;
    out_d = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
    disc_d = redirect ? out_q - CW'(imem_rsp_valid) : disc_q - CW'(imem_rsp_valid && disc_q != '0);
  end
  // PC and in-flight counter registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q <= '0;
      disc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q <= out_d;
      disc_q <= disc_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .T(entry_t), .RST_VAL(RST_ENTRY)) u_fifo (
    .clk_i  (i_clk),
    .rst_ni (i_rstn),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(redirect),
    .din_i  ('{pc: rsp_pc_q, instr: imem_rsp_data}),
    .head_o (head),
    .count_o(count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenario tests against an in-order fixed-latency imem model
module tb_fetch_unit;
  localparam logic [31:0] RST = 32'hFFFF_FFF8;
  logic i_clk = 1'b0, i_rstn, redirect, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic dec_valid, dec_ready;
  logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, dec_pc, dec_instr;
  int n_tests = 0, n_fail = 0, lat = 1, cyc = 0;
  logic [31:0] qa [$];
  int qd [$];

  fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(RST), .DEPTH(4)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_instr(dec_instr)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // imem model: accepted in cycle c, answered in cycle c+lat, in order
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    forever begin
      @(negedge i_clk);
      if (i_rstn && imem_req_valid && imem_req_ready) begin
        qa.push_back(imem_req_addr);
        qd.push_back(cyc + lat);
      end
      @(posedge i_clk);
      cyc++;
      #1;
      if (!i_rstn) begin
        qa.delete();
        qd.delete();
      end
      imem_rsp_valid = 1'b0;
      if (qd.size() != 0 && qd[0] == cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = f(qa[0]);
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic test_reset();
    i_rstn = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_req_ready = 1'b1; dec_ready = 1'b1; lat = 1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid got=%b exp=0", dec_valid); end
    n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    n_tests++; if (imem_req_addr !== RST) begin n_fail++; $display("FAIL reset_req_addr got=%h exp=%h", imem_req_addr, RST); end
    n_tests++; if (dec_pc !== RST) begin n_fail++; $display("FAIL reset_dec_pc got=%h exp=%h", dec_pc, RST); end
    n_tests++; if (dec_instr !== 32'h0) begin n_fail++; $display("FAIL reset_dec_instr got=%h exp=0", dec_instr); end
    @(posedge i_clk);
    #2 i_rstn = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] pc, ep;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      pc = RST + 32'(4 * k);
      n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== pc) begin n_fail++; $display("FAIL stream_req k=%0d got=%b/%h exp=1/%h", k, imem_req_valid, imem_req_addr, pc); end
      if (k >= 2) begin
        ep = RST + 32'(4 * (k - 2));
        n_tests++; if (dec_valid !== 1'b1 || dec_pc !== ep || dec_instr !== f(ep)) begin n_fail++; $display("FAIL stream_dec k=%0d got=%b/%h/%h exp=1/%h/%h", k, dec_valid, dec_pc, dec_instr, ep, f(ep)); end
      end else begin
        n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early k=%0d got=%b exp=0", k, dec_valid); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int fires = 0, got = 0;
    logic [31:0] exp = 32'h2000;
    redirect = 1'b1; redirect_pc = 32'h2000;
    @(negedge i_clk);
    n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_cycle_req got=%b exp=0", imem_req_valid); end
    n_tests++; if (dec_valid !== 1'b1 || imem_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL redir_cycle_busy got=%b/%b exp=1/1", dec_valid, imem_rsp_valid); end
    step();
    redirect = 1'b0; dec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (i == 0) begin
        n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush got=%b exp=0", dec_valid); end
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h2000) begin n_fail++; $display("FAIL redir_next_req got=%b/%h exp=1/00002000", imem_req_valid, imem_req_addr); end
      end
      if (imem_req_valid && imem_req_ready) fires++;
      step();
    end
    @(negedge i_clk);
    n_tests++; if (fires != 4) begin n_fail++; $display("FAIL bp_fires got=%0d exp=4", fires); end
    n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_stop got=%b exp=0", imem_req_valid); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 32'h2000 || dec_instr !== f(32'h2000)) begin n_fail++; $display("FAIL bp_hold i=%0d got=%b/%h/%h exp=1/00002000/%h", i, dec_valid, dec_pc, dec_instr, f(32'h2000)); end
      step();
      @(negedge i_clk);
    end
    step();
    dec_ready = 1'b1;
    for (int i = 0; i < 40 && got < 12; i++) begin
      @(negedge i_clk);
      if (dec_valid) begin
        n_tests++; if (dec_pc !== exp || dec_instr !== f(exp)) begin n_fail++; $display("FAIL bp_resume n=%0d got=%h/%h exp=%h/%h", got, dec_pc, dec_instr, exp, f(exp)); end
        exp += 32'd4;
        got++;
      end
      step();
    end
    n_tests++; if (got != 12) begin n_fail++; $display("FAIL bp_resume_count got=%0d exp=12", got); end
  endtask

  task automatic test_redirect_l3();
    lat = 3; imem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h3000;
    step();
    redirect = 1'b0;
    repeat (6) step();
    imem_req_ready = 1'b1;
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'h1002;
    @(negedge i_clk);
    n_tests++; if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin n_fail++; $display("FAIL l3_redir_cycle got=%b/%b exp=0/0", imem_req_valid, dec_valid); end
    step();
    redirect = 1'b0;
    @(negedge i_clk);
    n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1000) begin n_fail++; $display("FAIL l3_req got=%b/%h exp=1/00001000", imem_req_valid, imem_req_addr); end
    for (int j = 4; j < 8; j++) begin
      n_tests++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL l3_stale j=%0d got=%b exp=0", j, dec_valid); end
      step();
      @(negedge i_clk);
    end
    n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 32'h1000 || dec_instr !== f(32'h1000)) begin n_fail++; $display("FAIL l3_first got=%b/%h/%h exp=1/00001000/%h", dec_valid, dec_pc, dec_instr, f(32'h1000)); end
    step();
    @(negedge i_clk);
    n_tests++; if (dec_valid !== 1'b1 || dec_pc !== 32'h1004 || dec_instr !== f(32'h1004)) begin n_fail++; $display("FAIL l3_second got=%b/%h/%h exp=1/00001004/%h", dec_valid, dec_pc, dec_instr, f(32'h1004)); end
    step();
  endtask

  task automatic test_reset_mid();
    dec_ready = 1'b0;
    repeat (10) step();
    @(negedge i_clk);
    n_tests++; if (dec_valid !== 1'b1 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL full_before_rst got=%b/%b exp=1/0", dec_valid, imem_req_valid); end
    #2 i_rstn = 1'b0;
    #1;
    n_tests++; if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst got=%b/%b exp=0/0", dec_valid, imem_req_valid); end
    n_tests++; if (dec_pc !== RST || dec_instr !== 32'h0) begin n_fail++; $display("FAIL async_rst_head got=%h/%h exp=%h/0", dec_pc, dec_instr, RST); end
    lat = 1; dec_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #2 i_rstn = 1'b1;
    @(negedge i_clk);
    n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST || dec_valid !== 1'b0) begin n_fail++; $display("FAIL restart_req got=%b/%h/%b exp=1/%h/0", imem_req_valid, imem_req_addr, dec_valid, RST); end
    step();
    step();
    @(negedge i_clk);
    n_tests++; if (dec_valid !== 1'b1 || dec_pc !== RST || dec_instr !== f(RST)) begin n_fail++; $display("FAIL restart_dec got=%b/%h/%h exp=1/%h/%h", dec_valid, dec_pc, dec_instr, RST, f(RST)); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_l3();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
